game_sequencer: RTL

//  Central controller for the shooter/catcher LED game. Runs from one clk and replaces the

---
 rtl/game_pkg.sv | 37 +++
 rtl/game_sequencer_if.sv | 34 +++
 rtl/game_sequencer_tick_divider.sv | 37 +++
 rtl/game_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the shooter/catcher game sequencer:
//   - state encoding (the low two bits are the externally reported state)
//   - default divider constants for the real-time build
//   - scoring constants and a helper that sizes divider counters
// ----------------------------------------------------------------------------
package game_pkg;

   // CLEAR sits at 3'b100 so that its low two bits read as IDLE on the
   // state port without any extra decode.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'b000,
      ST_PLAY  = 3'b001,
      ST_WIN   = 3'b010,
      ST_OVER  = 3'b011,
      ST_CLEAR = 3'b100
   } state_e;

   localparam int DEF_SCAN_DIV  = 50_000;
   localparam int DEF_CTRL_DIV  = 5_000_000;
   localparam int DEF_STEP_DIV0 = 75_000_000;
   localparam int DEF_STEP_DEC  = 12_500_000;
   localparam int DEF_STEP_MIN  = 25_000_000;
   localparam int DEF_LIVES     = 3;
   localparam int DEF_WIN_SCORE = 9;

   localparam int HITS_PER_LEVEL = 3;
   localparam int MAX_LEVEL      = 3;

   // Counter width able to hold the period value itself, so the period
   // register never truncates when a divider is a power of two.
   function automatic int div_width(input int div);
      return $clog2(div + 1);
   endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// ----------------------------------------------------------------------------
// game_if
// Bundle between the sequencer and its environment (datapath + buttons).
//   start            raw start button (asynchronous)
//   hit / miss       datapath step results, meaningful only with step_en
//   scan_en/ctrl_en/step_en  single-cycle timing enables
//   clear            one-cycle matrix reset request
//   play, state, score, lives, level   game status
// slave  = sequencer side, master = datapath / stimulus side.
// ----------------------------------------------------------------------------
interface game_if;
   logic       start;
   logic       hit;
   logic       miss;
   logic       scan_en;
   logic       ctrl_en;
   logic       step_en;
   logic       clear;
   logic       play;
   logic [1:0] state;
   logic [3:0] score;
   logic [1:0] lives;
   logic [1:0] level;

   modport slave (
      input  start, hit, miss,
      output scan_en, ctrl_en, step_en, clear, play, state, score, lives, level
   );

   modport master (
      output start, hit, miss,
      input  scan_en, ctrl_en, step_en, clear, play, state, score, lives, level
   );
endinterface

// File: rtl/game_sequencer_tick_divider.sv
// ----------------------------------------------------------------------------
// tick_divider
// Free-running modulo counter producing a one-cycle tick every `period`
// cycles while enabled.
//   clk, rst_n   clock, asynchronous active-low reset
//   en           count enable; low holds the counter at 0
//   period       cycles per tick (may change at runtime)
//   tick         high for one cycle when count == period-1
// ----------------------------------------------------------------------------
module tick_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] period,
   output logic             tick
);

   logic [WIDTH-1:0] r_count;
   logic             w_wrap;

   assign w_wrap = (r_count == period - WIDTH'(1));
   assign tick   = en & w_wrap;

   // The count returns to 0 on the tick cycle itself, so a period written
   // on a tick edge governs the very next interval.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (!en || w_wrap)
         r_count <= '0;
      else
         r_count <= r_count + WIDTH'(1);
   end

endmodule

// File: rtl/game_sequencer.sv
// ----------------------------------------------------------------------------
// game_sequencer
// Central controller of the LED shooter/catcher game. Generates the scan,
// control and step enables from one clock, sequences IDLE/PLAY/WIN/OVER and
// owns score, lives and speed level.
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   bus     game_if.slave: start/hit/miss in; enables, clear and status out
// ----------------------------------------------------------------------------
module game_sequencer
   import game_pkg::*;
#(
   parameter int SCAN_DIV  = DEF_SCAN_DIV,
   parameter int CTRL_DIV  = DEF_CTRL_DIV,
   parameter int STEP_DIV0 = DEF_STEP_DIV0,
   parameter int STEP_DEC  = DEF_STEP_DEC,
   parameter int STEP_MIN  = DEF_STEP_MIN,
   parameter int LIVES     = DEF_LIVES,
   parameter int WIN_SCORE = DEF_WIN_SCORE
) (
   input  logic  clk,
   input  logic  rst_n,
   game_if.slave bus
);

   localparam int SCAN_W = div_width(SCAN_DIV);
   localparam int CTRL_W = div_width(CTRL_DIV);
   localparam int STEP_W = div_width(STEP_DIV0);

   localparam logic [SCAN_W-1:0] SCAN_P     = SCAN_W'(SCAN_DIV);
   localparam logic [CTRL_W-1:0] CTRL_P     = CTRL_W'(CTRL_DIV);
   localparam logic [STEP_W-1:0] STEP_P0    = STEP_W'(STEP_DIV0);
   localparam logic [STEP_W-1:0] STEP_D     = STEP_W'(STEP_DEC);
   localparam logic [STEP_W-1:0] STEP_M     = STEP_W'(STEP_MIN);
   // At or above this period a full decrement still lands on/above the floor.
   localparam logic [STEP_W-1:0] STEP_FLOOR = STEP_W'(STEP_MIN + STEP_DEC);

   state_e              r_state, w_next;
   logic [1:0]          r_sync;
   logic                r_start_d;
   logic [3:0]          r_score;
   logic [1:0]          r_lives;
   logic [1:0]          r_level;
   logic [1:0]          r_hit_cnt;
   logic [STEP_W-1:0]   r_step_period;

   logic                w_start_pulse;
   logic                w_play, w_clear;
   logic                w_scan_tick, w_ctrl_tick, w_step_tick;
   logic                w_hit_ev, w_miss_ev, w_level_up;
   logic [2:0]          w_state_code;

   // ---------------- timing enables ----------------
   tick_divider #(.WIDTH(SCAN_W)) u_scan (
      .clk(clk), .rst_n(rst_n), .en(1'b1),   .period(SCAN_P),        .tick(w_scan_tick));
   tick_divider #(.WIDTH(CTRL_W)) u_ctrl (
      .clk(clk), .rst_n(rst_n), .en(w_play), .period(CTRL_P),        .tick(w_ctrl_tick));
   tick_divider #(.WIDTH(STEP_W)) u_step (
      .clk(clk), .rst_n(rst_n), .en(w_play), .period(r_step_period), .tick(w_step_tick));

   // ---------------- start synchroniser + edge detect ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync    <= 2'b00;
         r_start_d <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], bus.start};
         r_start_d <= r_sync[1];
      end
   end

   assign w_start_pulse = r_sync[1] & ~r_start_d;

   // ---------------- event decode ----------------
   assign w_play     = (r_state == ST_PLAY);
   assign w_clear    = (r_state == ST_CLEAR);
   assign w_hit_ev   = w_play & w_step_tick & bus.hit;
   // A simultaneous hit wins; the miss is dropped.
   assign w_miss_ev  = w_play & w_step_tick & bus.miss & ~bus.hit;
   assign w_level_up = w_hit_ev & (r_hit_cnt == 2'(HITS_PER_LEVEL - 1));

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_start_pulse) w_next = ST_CLEAR;
         ST_CLEAR: w_next = ST_PLAY;
         ST_PLAY: begin
            if (w_hit_ev && (r_score == 4'(WIN_SCORE - 1)))
               w_next = ST_WIN;
            else if (w_miss_ev && (r_lives == 2'd1))
               w_next = ST_OVER;
         end
         ST_WIN, ST_OVER: if (w_start_pulse) w_next = ST_CLEAR;
         default:  w_next = ST_IDLE;
      endcase
   end

   // ---------------- score / lives / level / speed ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_score       <= 4'd0;
         r_lives       <= 2'(LIVES);
         r_level       <= 2'd0;
         r_hit_cnt     <= 2'd0;
         r_step_period <= STEP_P0;
      end else if (w_clear) begin
         r_score       <= 4'd0;
         r_lives       <= 2'(LIVES);
         r_level       <= 2'd0;
         r_hit_cnt     <= 2'd0;
         r_step_period <= STEP_P0;
      end else if (w_hit_ev) begin
         // Reaching WIN_SCORE leaves PLAY on this edge, so score cannot pass it.
         r_score <= r_score + 4'd1;
         if (w_level_up) begin
            r_hit_cnt <= 2'd0;
            if (r_level != 2'(MAX_LEVEL))
               r_level <= r_level + 2'd1;
            r_step_period <= (r_step_period >= STEP_FLOOR) ? r_step_period - STEP_D : STEP_M;
         end else begin
            r_hit_cnt <= r_hit_cnt + 2'd1;
         end
      end else if (w_miss_ev) begin
         if (r_lives != 2'd0)
            r_lives <= r_lives - 2'd1;
      end
   end

   // ---------------- outputs ----------------
   assign w_state_code = r_state;
   assign bus.state    = w_state_code[1:0];
   assign bus.play     = w_play;
   assign bus.clear    = w_clear;
   assign bus.scan_en  = w_scan_tick;
   assign bus.ctrl_en  = w_ctrl_tick;
   assign bus.step_en  = w_step_tick;
   assign bus.score    = r_score;
   assign bus.lives    = r_lives;
   assign bus.level    = r_level;

endmodule
